// File: rtl/flac_seq_pkg.sv
// Shared types and defaults for the FLAC frame sequencer and its watchdog.
package flac_seq_pkg;

    localparam int ADDR_W                 = 16;
    localparam int DEFAULT_BLOCK_SIZE     = 4096;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1 << 20;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_GUARD,
        ST_RUN,
        ST_RECORD,
        ST_FINISH
    } seq_state_e;

    // A frame is a full block unless only a remainder is left.
    function automatic addr_t frame_size(input addr_t remaining, input addr_t block);
        return (remaining > block) ? block : remaining;
    endfunction

endpackage

// File: rtl/flac_frame_sequencer_if.sv
// System-control and encoder-side signals of the frame sequencer.
// slave = sequencer side, master = system/encoder side.
interface flac_frame_sequencer_if;
    import flac_seq_pkg::*;

    logic  iStart;
    addr_t iTotalSamples;
    addr_t iInBase;
    addr_t iOutBase;
    logic  oEncReset;
    addr_t oEncNumSamples;
    addr_t oEncIAddrStart;
    addr_t oEncOAddrStart;
    addr_t iEncOAddress;
    logic  iEncDone;
    logic  oBusy;
    logic  oFrameValid;
    addr_t oFrameStart;
    addr_t oFrameLen;
    addr_t oFrameCount;
    logic  oDone;
    logic  oError;

    modport slave (
        input  iStart, iTotalSamples, iInBase, iOutBase, iEncOAddress, iEncDone,
        output oEncReset, oEncNumSamples, oEncIAddrStart, oEncOAddrStart,
               oBusy, oFrameValid, oFrameStart, oFrameLen, oFrameCount, oDone, oError
    );

    modport master (
        output iStart, iTotalSamples, iInBase, iOutBase, iEncOAddress, iEncDone,
        input  oEncReset, oEncNumSamples, oEncIAddrStart, oEncOAddrStart,
               oBusy, oFrameValid, oFrameStart, oFrameLen, oFrameCount, oDone, oError
    );

endinterface

// File: rtl/flac_seq_watchdog.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle after a clear.
module flac_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = flac_seq_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/flac_frame_sequencer.sv
// Splits a PCM stream into blocks and runs one encoder pass per block, packing frames back to back.
// Optional watchdog abort in RUN is enabled by defining FLAC_SEQ_WATCHDOG_EN.
module flac_frame_sequencer
    import flac_seq_pkg::*;
#(
    parameter int BLOCK_SIZE     = DEFAULT_BLOCK_SIZE,
    parameter int RESET_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   iClock,
    input  logic                   iReset,
    flac_frame_sequencer_if.slave  bus
);

    localparam addr_t BLOCK_LEN   = addr_t'(BLOCK_SIZE);
    localparam addr_t LAUNCH_LAST = addr_t'(RESET_CYCLES - 1);

    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("flac_frame_sequencer: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    seq_state_e state_q, state_d;
    addr_t remaining_q, remaining_d;
    addr_t in_addr_q, in_addr_d;
    addr_t out_addr_q, out_addr_d;
    addr_t num_q, num_d;
    addr_t launch_cnt_q, launch_cnt_d;
    addr_t frame_start_q, frame_start_d;
    addr_t frame_len_q, frame_len_d;
    addr_t frame_count_q, frame_count_d;

`ifdef FLAC_SEQ_WATCHDOG_EN
    logic error_q, error_d;
    logic wd_expire;

    flac_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (iClock),
        .rst    (iReset),
        .clear  (state_q != ST_RUN),
        .enable (state_q == ST_RUN),
        .expire (wd_expire)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.oError = error_q;
`else
    assign bus.oError = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        in_addr_d     = in_addr_q;
        out_addr_d    = out_addr_q;
        num_d         = num_q;
        launch_cnt_d  = launch_cnt_q;
        frame_start_d = frame_start_q;
        frame_len_d   = frame_len_q;
        frame_count_d = frame_count_q;
`ifdef FLAC_SEQ_WATCHDOG_EN
        error_d       = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    remaining_d   = bus.iTotalSamples;
                    in_addr_d     = bus.iInBase;
                    out_addr_d    = bus.iOutBase;
                    num_d         = frame_size(bus.iTotalSamples, BLOCK_LEN);
                    launch_cnt_d  = '0;
                    frame_start_d = '0;
                    frame_len_d   = '0;
                    frame_count_d = '0;
`ifdef FLAC_SEQ_WATCHDOG_EN
                    error_d       = 1'b0;
`endif
                    state_d = (bus.iTotalSamples == '0) ? ST_FINISH : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (launch_cnt_q == LAUNCH_LAST) begin
                    state_d = ST_GUARD;
                end else begin
                    launch_cnt_d = launch_cnt_q + 1'b1;
                end
            end
            ST_GUARD: state_d = ST_RUN;
            ST_RUN: begin
                // Frame record is captured on the way into RECORD so it is valid during the strobe.
                if (bus.iEncDone) begin
                    frame_start_d = out_addr_q;
                    frame_len_d   = bus.iEncOAddress - out_addr_q + 16'd1;
                    frame_count_d = (frame_count_q == '1) ? frame_count_q : frame_count_q + 1'b1;
                    state_d       = ST_RECORD;
                end
`ifdef FLAC_SEQ_WATCHDOG_EN
                else if (wd_expire) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end
`endif
            end
            ST_RECORD: begin
                remaining_d  = remaining_q - num_q;
                in_addr_d    = in_addr_q + num_q;
                out_addr_d   = frame_start_q + frame_len_q;
                num_d        = frame_size(remaining_d, BLOCK_LEN);
                launch_cnt_d = '0;
                state_d      = (remaining_d == '0) ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            in_addr_q     <= '0;
            out_addr_q    <= '0;
            num_q         <= '0;
            launch_cnt_q  <= '0;
            frame_start_q <= '0;
            frame_len_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            in_addr_q     <= in_addr_d;
            out_addr_q    <= out_addr_d;
            num_q         <= num_d;
            launch_cnt_q  <= launch_cnt_d;
            frame_start_q <= frame_start_d;
            frame_len_q   <= frame_len_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Encoder is released only while a block is actually being encoded or recorded.
    assign bus.oEncReset      = !(state_q == ST_GUARD || state_q == ST_RUN || state_q == ST_RECORD);
    assign bus.oEncNumSamples = num_q;
    assign bus.oEncIAddrStart = in_addr_q;
    assign bus.oEncOAddrStart = out_addr_q;
    assign bus.oBusy          = (state_q != ST_IDLE);
    assign bus.oFrameValid    = (state_q == ST_RECORD);
    assign bus.oFrameStart    = frame_start_q;
    assign bus.oFrameLen      = frame_len_q;
    assign bus.oFrameCount    = frame_count_q;
    assign bus.oDone          = (state_q == ST_FINISH);

endmodule

// File: tb/tb_flac_frame_sequencer.sv
// Self-checking bench for flac_frame_sequencer: directed and randomized streams against a block-splitting model.
// Watchdog checks are compiled in when FLAC_SEQ_WATCHDOG_EN is defined.
module tb_flac_frame_sequencer;

    localparam int BS  = 4;
    localparam int RST = 2;
    localparam int TO  = 50;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    flac_frame_sequencer_if bus ();

    flac_frame_sequencer #(
        .BLOCK_SIZE     (BS),
        .RESET_CYCLES   (RST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one stream and plays the encoder; expectations come from plain block arithmetic.
    task automatic run_stream(input int total, input logic [15:0] in_base, input logic [15:0] out_base,
                              input int fixed_words, input bit stale);
        int rem, nframes, wait_cnt, words, lat, ns;
        logic [15:0] ia, oa, last_start;
        bus.iTotalSamples = total[15:0];
        bus.iInBase       = in_base;
        bus.iOutBase      = out_base;
        bus.iStart        = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        if (total == 0) begin
            check("zero_done", bus.oDone, 1);
            check("zero_encreset", bus.oEncReset, 1);
            check("zero_count", bus.oFrameCount, 0);
            @(negedge clk);
            check("zero_done_once", bus.oDone, 0);
            check("zero_idle", bus.oBusy, 0);
            check("zero_encreset_idle", bus.oEncReset, 1);
            return;
        end
        rem        = total;
        ia         = in_base;
        oa         = out_base;
        last_start = out_base;
        nframes    = (total + BS - 1) / BS;
        for (int k = 0; k < nframes; k++) begin
            wait_cnt = 0;
            while (bus.oEncReset && wait_cnt < 20) begin
                wait_cnt++;
                @(negedge clk);
            end
            check("launch_cycles", wait_cnt, RST);
            if (wait_cnt >= 20) begin
                bus.iEncDone = 1'b0;
                return;
            end
            ns = (rem < BS) ? rem : BS;
            check("num_samples", bus.oEncNumSamples, ns);
            check("iaddr_start", bus.oEncIAddrStart, ia);
            check("oaddr_start", bus.oEncOAddrStart, oa);
            check("busy_guard", bus.oBusy, 1);
            words = (fixed_words != 0) ? fixed_words : int'($urandom_range(1, 8));
            lat   = int'($urandom_range(1, 4));
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                bus.iEncDone = 1'b0;
                if (k == 0 && c == 0) bus.iStart = 1'b1;
                check("no_early_record", bus.oFrameValid, 0);
            end
            bus.iEncOAddress = oa + 16'(words) - 16'd1;
            bus.iEncDone     = 1'b1;
            bus.iStart       = 1'b0;
            @(negedge clk);
            check("frame_valid", bus.oFrameValid, 1);
            check("frame_start", bus.oFrameStart, oa);
            check("frame_len", bus.oFrameLen, words);
            check("frame_count", bus.oFrameCount, k + 1);
            check("oaddr_stable", bus.oEncOAddrStart, oa);
            bus.iEncDone = stale;
            last_start   = oa;
            rem          = rem - ns;
            ia           = ia + 16'(ns);
            oa           = oa + 16'(words);
            @(negedge clk);
        end
        bus.iEncDone = 1'b0;
        check("done_strobe", bus.oDone, 1);
        check("done_encreset", bus.oEncReset, 1);
        check("done_no_valid", bus.oFrameValid, 0);
        @(negedge clk);
        check("done_once", bus.oDone, 0);
        check("idle_after_done", bus.oBusy, 0);
        check("final_count", bus.oFrameCount, nframes);
        check("hold_frame_start", bus.oFrameStart, last_start);
        check("error_clear", bus.oError, 0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.iStart        = 1'b0;
        bus.iTotalSamples = '0;
        bus.iInBase       = '0;
        bus.iOutBase      = '0;
        bus.iEncOAddress  = '0;
        bus.iEncDone      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_encreset", bus.oEncReset, 1);
        check("rst_busy", bus.oBusy, 0);
        check("rst_num", bus.oEncNumSamples, 0);
        check("rst_iaddr", bus.oEncIAddrStart, 0);
        check("rst_oaddr", bus.oEncOAddrStart, 0);
        check("rst_valid", bus.oFrameValid, 0);
        check("rst_fstart", bus.oFrameStart, 0);
        check("rst_flen", bus.oFrameLen, 0);
        check("rst_count", bus.oFrameCount, 0);
        check("rst_done", bus.oDone, 0);
        check("rst_error", bus.oError, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", bus.oBusy, 0);

        $display("[TB] directed 10-sample stream, 3 words per frame");
        run_stream(10, 16'd0, 16'd100, 3, 1'b0);
        $display("[TB] stale done held into GUARD");
        run_stream(9, 16'h0020, 16'h0040, 0, 1'b1);
        $display("[TB] output address wrap");
        run_stream(8, 16'd0, 16'hFFFE, 4, 1'b0);
        $display("[TB] empty stream");
        run_stream(0, 16'd5, 16'd7, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_stream(int'($urandom_range(1, 13)), 16'($urandom), 16'($urandom), 0, r[0]);
        end

        $display("[TB] reset asserted mid-run");
        bus.iTotalSamples = 16'd8;
        bus.iStart        = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        n = 0;
        while (bus.oEncReset && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("mid_reset_reached_guard", bus.oEncReset, 0);
        repeat (2) @(negedge clk);
        check("mid_reset_running", bus.oBusy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_encreset", bus.oEncReset, 1);
        check("mid_reset_busy", bus.oBusy, 0);
        check("mid_reset_count", bus.oFrameCount, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_stays_idle", bus.oBusy, 0);

`ifdef FLAC_SEQ_WATCHDOG_EN
        $display("[TB] watchdog timeout");
        bus.iTotalSamples = 16'd4;
        bus.iStart        = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        n = 0;
        while (bus.oEncReset && n < 20) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("wd_no_valid", bus.oFrameValid, 0);
        end while (!bus.oDone && n < 200);
        check("wd_expire_cycle", n, TO + 1);
        check("wd_error", bus.oError, 1);
        check("wd_encreset", bus.oEncReset, 1);
        @(negedge clk);
        check("wd_error_sticky", bus.oError, 1);
        run_stream(0, 16'd0, 16'd0, 0, 1'b0);
        check("wd_error_cleared", bus.oError, 0);
`else
        check("error_tied_low", bus.oError, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
